mem_boot_loader: RTL and testbench

//  Host-side driver of the CPU external memory ports: the writer/reader at the far end of addr_ext*/wen_ext*/ren_ext*.

---
 rtl/mem_boot_loader.sv | 180 ++++++++++++++++++
 tb/tb_mem_boot_loader.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_boot_loader.sv
// Host-side memory loader: streams IMEM/DMEM images in, runs the cpu for a cycle budget, streams a DMEM window out.
// Optional feature macro LOADER_CHECKSUM_EN: o_checksum carries a wrapping sum of the dumped words.
module mem_boot_loader #(
  parameter int IMEM_DEPTH = 512,
  parameter int DMEM_DEPTH = 1024,
  parameter int LEN_W      = 11,
  parameter int CYC_W      = 32
) (
  input  logic             i_clk,
  input  logic             i_arst,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_imem_len,
  input  logic [LEN_W-1:0] i_dmem_len,
  input  logic [CYC_W-1:0] i_run_cycles,
  input  logic [LEN_W-1:0] i_dump_len,
  input  logic             i_s_valid,
  output logic             o_s_ready,
  input  logic [63:0]      i_s_data,
  output logic             o_m_valid,
  input  logic             i_m_ready,
  output logic [63:0]      o_m_data,
  output logic             o_cpu_enable,
  output logic [63:0]      o_addr_ext,
  output logic             o_wen_ext,
  output logic             o_ren_ext,
  output logic [31:0]      o_wdata_ext,
  output logic [63:0]      o_addr_ext_2,
  output logic             o_wen_ext_2,
  output logic             o_ren_ext_2,
  output logic [63:0]      o_wdata_ext_2,
  input  logic [63:0]      i_rdata_ext_2,
  output logic             o_busy,
  output logic             o_done,
  output logic [63:0]      o_checksum
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_I, S_LOAD_D, S_RUN, S_DUMP_RD, S_DUMP_WAIT, S_DUMP_OUT, S_DONE
  } state_t;

  localparam logic [LEN_W-1:0] IMAX = LEN_W'(IMEM_DEPTH);
  localparam logic [LEN_W-1:0] DMAX = LEN_W'(DMEM_DEPTH);

  state_t           r_state, w_next;
  logic [LEN_W-1:0] r_ilen, r_dlen, r_dump, r_idx;
  logic [CYC_W-1:0] r_cyc;
  logic [63:0]      r_mdata;
  logic [LEN_W-1:0] w_ilen, w_dlen, w_dump, w_idx_inc, w_cur_len;
  logic [63:0]      w_addr_i, w_addr_d;
  logic             w_start_ok, w_s_hs, w_m_hs, w_last;

  // First non-empty phase of the session; empty phases are skipped in the same transition.
  function automatic state_t pick(input logic i, input logic d, input logic r, input logic m);
    if (i)      return S_LOAD_I;
    else if (d) return S_LOAD_D;
    else if (r) return S_RUN;
    else if (m) return S_DUMP_RD;
    else        return S_DONE;
  endfunction

  assign w_ilen     = (i_imem_len > IMAX) ? IMAX : i_imem_len;
  assign w_dlen     = (i_dmem_len > DMAX) ? DMAX : i_dmem_len;
  assign w_dump     = (i_dump_len > DMAX) ? DMAX : i_dump_len;
  assign w_start_ok = i_start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_s_hs     = i_s_valid && (r_state == S_LOAD_I || r_state == S_LOAD_D);
  assign w_m_hs     = i_m_ready && (r_state == S_DUMP_OUT);
  assign w_idx_inc  = r_idx + LEN_W'(1);
  assign w_cur_len  = (r_state == S_LOAD_I) ? r_ilen : (r_state == S_LOAD_D) ? r_dlen : r_dump;
  assign w_last     = (w_idx_inc == w_cur_len);
  assign w_addr_i   = {{(62-LEN_W){1'b0}}, r_idx, 2'b00};
  assign w_addr_d   = {{(61-LEN_W){1'b0}}, r_idx, 3'b000};
  assign o_m_data   = r_mdata;

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE:
        if (i_start) w_next = pick(w_ilen != '0, w_dlen != '0, i_run_cycles != '0, w_dump != '0);
      S_LOAD_I:
        if (w_s_hs && w_last) w_next = pick(1'b0, r_dlen != '0, r_cyc != '0, r_dump != '0);
      S_LOAD_D:
        if (w_s_hs && w_last) w_next = pick(1'b0, 1'b0, r_cyc != '0, r_dump != '0);
      S_RUN:
        if (r_cyc == CYC_W'(1)) w_next = (r_dump != '0) ? S_DUMP_RD : S_DONE;
      S_DUMP_RD:   w_next = S_DUMP_WAIT;
      S_DUMP_WAIT: w_next = S_DUMP_OUT;
      S_DUMP_OUT:
        if (w_m_hs) w_next = w_last ? S_DONE : S_DUMP_RD;
      default:     w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_s_ready     = 1'b0;
    o_m_valid     = 1'b0;
    o_cpu_enable  = 1'b0;
    o_addr_ext    = '0;
    o_wen_ext     = 1'b0;
    o_ren_ext     = 1'b0;
    o_wdata_ext   = '0;
    o_addr_ext_2  = '0;
    o_wen_ext_2   = 1'b0;
    o_ren_ext_2   = 1'b0;
    o_wdata_ext_2 = '0;
    o_busy        = 1'b1;
    o_done        = 1'b0;
    case (r_state)
      S_IDLE: o_busy = 1'b0;
      S_LOAD_I: begin
        o_s_ready   = 1'b1;
        o_wen_ext   = i_s_valid;
        o_addr_ext  = w_addr_i;
        o_wdata_ext = i_s_data[31:0];
      end
      S_LOAD_D: begin
        o_s_ready     = 1'b1;
        o_wen_ext_2   = i_s_valid;
        o_addr_ext_2  = w_addr_d;
        o_wdata_ext_2 = i_s_data;
      end
      S_RUN: o_cpu_enable = 1'b1;
      S_DUMP_RD: begin
        o_ren_ext_2  = 1'b1;
        o_addr_ext_2 = w_addr_d;
      end
      S_DUMP_OUT: o_m_valid = 1'b1;
      S_DONE: begin
        o_busy = 1'b0;
        o_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Index walks the current phase and is back at 0 whenever a phase ends.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_ilen  <= '0;
      r_dlen  <= '0;
      r_dump  <= '0;
      r_idx   <= '0;
      r_cyc   <= '0;
      r_mdata <= '0;
    end else if (w_start_ok) begin
      r_ilen <= w_ilen;
      r_dlen <= w_dlen;
      r_dump <= w_dump;
      r_cyc  <= i_run_cycles;
      r_idx  <= '0;
    end else begin
      case (r_state)
        S_LOAD_I, S_LOAD_D:
          if (w_s_hs) r_idx <= w_last ? '0 : w_idx_inc;
        S_RUN:       r_cyc   <= r_cyc - CYC_W'(1);
        S_DUMP_WAIT: r_mdata <= i_rdata_ext_2;
        S_DUMP_OUT:
          if (w_m_hs) r_idx <= w_last ? '0 : w_idx_inc;
        default: ;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [63:0] r_csum;
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst)          r_csum <= '0;
    else if (w_start_ok) r_csum <= '0;
    else if (w_m_hs)     r_csum <= r_csum + r_mdata;
  end
  assign o_checksum = r_csum;
`else
  assign o_checksum = '0;
`endif

endmodule

// File: tb/tb_mem_boot_loader.sv
// Randomized bench for mem_boot_loader: a session-level reference model predicts writes, run length and dump words.
module tb_mem_boot_loader;
  logic        clk = 1'b0;
  logic        arst, start, s_valid, m_ready;
  logic [10:0] imem_len, dmem_len, dump_len;
  logic [31:0] run_cycles;
  logic [63:0] s_data;
  logic        s_ready, m_valid, cpu_enable, wen_ext, ren_ext, wen_ext_2, ren_ext_2, busy, done;
  logic [63:0] m_data, addr_ext, addr_ext_2, wdata_ext_2, checksum;
  logic [31:0] wdata_ext;
  logic [63:0] rdata_ext_2;

  always #5 clk = ~clk;

  mem_boot_loader dut (
    .i_clk(clk), .i_arst(arst), .i_start(start),
    .i_imem_len(imem_len), .i_dmem_len(dmem_len), .i_run_cycles(run_cycles), .i_dump_len(dump_len),
    .i_s_valid(s_valid), .o_s_ready(s_ready), .i_s_data(s_data),
    .o_m_valid(m_valid), .i_m_ready(m_ready), .o_m_data(m_data),
    .o_cpu_enable(cpu_enable),
    .o_addr_ext(addr_ext), .o_wen_ext(wen_ext), .o_ren_ext(ren_ext), .o_wdata_ext(wdata_ext),
    .o_addr_ext_2(addr_ext_2), .o_wen_ext_2(wen_ext_2), .o_ren_ext_2(ren_ext_2),
    .o_wdata_ext_2(wdata_ext_2), .i_rdata_ext_2(rdata_ext_2),
    .o_busy(busy), .o_done(done), .o_checksum(checksum)
  );

  // DMEM behaviour: synchronous write, read data valid the cycle after the strobe.
  logic [63:0] dmem [0:1023];
  always @(posedge clk) begin
    if (wen_ext_2) dmem[addr_ext_2[12:3]] <= wdata_ext_2;
    if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[12:3]];
  end

  int n_tests = 0, n_fail = 0;
  logic [63:0] wq[$], wsrc[$];
  logic [63:0] obs_ia[$], exp_ia[$], obs_da[$], exp_da[$], obs_dd[$], exp_dd[$], obs_dump[$], exp_dump[$];
  logic [31:0] obs_id[$], exp_id[$];
  logic [63:0] ref_dmem [0:1023];
  logic [63:0] exp_csum, prev_md;
  logic        mon_on = 1'b0, prev_stall;
  int          en_cnt, excl, unstable, busy_cyc, tmo, exp_busy, exp_en;
  int          dm_hi = 0;

  always @(negedge clk) begin
    if (mon_on) begin
      if (wen_ext)   begin obs_ia.push_back(addr_ext);   obs_id.push_back(wdata_ext);   end
      if (wen_ext_2) begin obs_da.push_back(addr_ext_2); obs_dd.push_back(wdata_ext_2); end
      if (cpu_enable) en_cnt++;
      if ((cpu_enable && (wen_ext || wen_ext_2 || ren_ext_2)) || ren_ext) excl++;
      if (prev_stall && (!m_valid || m_data !== prev_md)) unstable++;
      prev_stall = m_valid && !m_ready;
      prev_md    = m_data;
      if (m_valid && m_ready) obs_dump.push_back(m_data);
    end
  end

  task automatic clear_obs();
    obs_ia.delete(); obs_id.delete(); obs_da.delete(); obs_dd.delete(); obs_dump.delete();
    en_cnt = 0; excl = 0; unstable = 0; busy_cyc = 0; tmo = 0; prev_stall = 1'b0;
  endtask

  // Session model: what the host stream and the lengths imply, independent of cycle timing.
  task automatic model(input int il, input int dl, input int rc, input int dp);
    int ci, cd, cp;
    ci = (il > 512) ? 512 : il;
    cd = (dl > 1024) ? 1024 : dl;
    cp = (dp > 1024) ? 1024 : dp;
    exp_ia.delete(); exp_id.delete(); exp_da.delete(); exp_dd.delete(); exp_dump.delete();
    exp_csum = '0;
    for (int k = 0; k < ci; k++) begin exp_ia.push_back(64'(4*k)); exp_id.push_back(wsrc[k][31:0]); end
    for (int k = 0; k < cd; k++) begin
      exp_da.push_back(64'(8*k)); exp_dd.push_back(wsrc[ci+k]); ref_dmem[k] = wsrc[ci+k];
    end
    if (cd > dm_hi) dm_hi = cd;
    for (int k = 0; k < cp; k++) begin
      exp_dump.push_back(ref_dmem[k]);
`ifdef LOADER_CHECKSUM_EN
      exp_csum = exp_csum + ref_dmem[k];
`endif
    end
    exp_en   = rc;
    exp_busy = ci + cd + rc + 3*cp;
  endtask

  task automatic drive(input int cyc, input int vpat, input int mvc, input int mr_hold, input bit mr_rand);
    s_valid = (wq.size() > 0) && (vpat == 0 || (vpat == 1 && cyc % 2 == 1) ||
                                  (vpat == 2 && $urandom_range(0, 1) == 1));
    s_data  = (wq.size() > 0) ? wq[0] : {$urandom, $urandom};
    m_ready = (mvc >= mr_hold) && (!mr_rand || $urandom_range(0, 1) == 1);
  endtask

  // Drives one session (words from wsrc) until done or the cycle budget expires; no checking here.
  task automatic run_session(input int il, input int dl, input int rc, input int dp,
                             input int vpat, input int mr_hold, input bit mr_rand, input int mid_start);
    int cyc, mvc;
    bit acc;
    clear_obs();
    wq = wsrc;
    model(il, dl, rc, dp);
    mon_on = 1'b1;
    cyc = 0; mvc = 0;
    @(posedge clk); #1;
    imem_len = 11'(il); dmem_len = 11'(dl); run_cycles = 32'(rc); dump_len = 11'(dp);
    start = 1'b1;
    drive(0, vpat, 0, mr_hold, mr_rand);
    while (1) begin
      @(negedge clk);
      if (cyc > 0) begin
        if (done) break;
        if (busy) busy_cyc++;
      end
      acc = s_valid && s_ready;
      if (m_valid) mvc++;
      if (cyc > 6000) begin tmo = 1; break; end
      @(posedge clk); #1;
      cyc++;
      if (acc) void'(wq.pop_front());
      start = (cyc == mid_start);
      if (cyc == 1 || cyc == mid_start) begin
        imem_len = 11'($urandom); dmem_len = 11'($urandom); run_cycles = $urandom; dump_len = 11'($urandom);
      end
      drive(cyc, vpat, mvc, mr_hold, mr_rand);
    end
    start = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    mon_on = 1'b0;
  endtask

  task automatic test_reset();
    arst = 1'b1; start = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
    imem_len = '0; dmem_len = '0; run_cycles = '0; dump_len = '0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({s_ready, m_valid, cpu_enable, wen_ext, ren_ext, wen_ext_2, ren_ext_2, busy, done} !== 9'b0 ||
        addr_ext !== '0 || addr_ext_2 !== '0 || m_data !== '0 || checksum !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: flags=%b addr=%h addr2=%h mdata=%h csum=%h, want all 0",
               {s_ready, m_valid, cpu_enable, wen_ext, ren_ext, wen_ext_2, ren_ext_2, busy, done},
               addr_ext, addr_ext_2, m_data, checksum);
    end
    arst = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_load();
    wsrc.delete();
    for (int k = 0; k < 5; k++) wsrc.push_back({$urandom, $urandom});
    run_session(3, 2, 0, 0, 0, 0, 1'b0, -1);
    n_tests++;
    if (tmo != 0 || done !== 1'b1 || busy_cyc != exp_busy) begin
      n_fail++; $display("FAIL load_done: tmo=%0d done=%b busy_cycles=%0d want 0 1 %0d", tmo, done, busy_cyc, exp_busy);
    end
    n_tests++;
    if (obs_ia.size() != 3 || obs_da.size() != 2 || en_cnt != 0 || excl != 0) begin
      n_fail++; $display("FAIL load_counts: iw=%0d dw=%0d en=%0d excl=%0d want 3 2 0 0", obs_ia.size(), obs_da.size(), en_cnt, excl);
    end
    for (int k = 0; k < obs_ia.size() && k < exp_ia.size(); k++) begin
      n_tests++;
      if (obs_ia[k] !== exp_ia[k] || obs_id[k] !== exp_id[k]) begin
        n_fail++; $display("FAIL load_imem[%0d]: got %h/%h want %h/%h", k, obs_ia[k], obs_id[k], exp_ia[k], exp_id[k]);
      end
    end
    for (int k = 0; k < obs_da.size() && k < exp_da.size(); k++) begin
      n_tests++;
      if (obs_da[k] !== exp_da[k] || obs_dd[k] !== exp_dd[k]) begin
        n_fail++; $display("FAIL load_dmem[%0d]: got %h/%h want %h/%h", k, obs_da[k], obs_dd[k], exp_da[k], exp_dd[k]);
      end
    end
  endtask

  task automatic test_run();
    wsrc.delete();
    run_session(0, 0, 10, 0, 0, 0, 1'b0, -1);
    n_tests++;
    if (en_cnt != exp_en || busy_cyc != exp_busy || tmo != 0 || done !== 1'b1) begin
      n_fail++; $display("FAIL run_len: en=%0d busy=%0d tmo=%0d done=%b want %0d %0d 0 1", en_cnt, busy_cyc, tmo, done, exp_en, exp_busy);
    end
    n_tests++;
    if (obs_ia.size() != 0 || obs_da.size() != 0 || excl != 0) begin
      n_fail++; $display("FAIL run_strobes: iw=%0d dw=%0d excl=%0d want 0 0 0", obs_ia.size(), obs_da.size(), excl);
    end
  endtask

  task automatic test_dump();
    wsrc.delete(); wsrc.push_back(64'd5); wsrc.push_back(64'd7);
    run_session(0, 2, 0, 2, 0, 4, 1'b0, -1);
    n_tests++;
    if (obs_dump.size() != 2 || tmo != 0 || unstable != 0 || busy_cyc != exp_busy + 4) begin
      n_fail++; $display("FAIL dump_flow: words=%0d tmo=%0d unstable=%0d busy=%0d want 2 0 0 %0d",
                         obs_dump.size(), tmo, unstable, busy_cyc, exp_busy + 4);
    end
    for (int k = 0; k < obs_dump.size() && k < exp_dump.size(); k++) begin
      n_tests++;
      if (obs_dump[k] !== exp_dump[k]) begin
        n_fail++; $display("FAIL dump_word[%0d]: got %h want %h", k, obs_dump[k], exp_dump[k]);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (checksum !== exp_csum || done !== 1'b1) begin
      n_fail++; $display("FAIL dump_checksum: got %h done=%b want %h 1", checksum, done, exp_csum);
    end
  endtask

  task automatic test_gaps();
    wsrc.delete();
    for (int k = 0; k < 4; k++) wsrc.push_back({$urandom, $urandom});
    run_session(2, 0, 0, 0, 1, 0, 1'b0, -1);
    n_tests++;
    if (obs_ia.size() != 2 || tmo != 0) begin
      n_fail++; $display("FAIL gaps_count: writes=%0d tmo=%0d want 2 0", obs_ia.size(), tmo);
    end
    for (int k = 0; k < obs_ia.size() && k < exp_ia.size(); k++) begin
      n_tests++;
      if (obs_ia[k] !== exp_ia[k] || obs_id[k] !== exp_id[k]) begin
        n_fail++; $display("FAIL gaps_imem[%0d]: got %h/%h want %h/%h", k, obs_ia[k], obs_id[k], exp_ia[k], exp_id[k]);
      end
    end
  endtask

  task automatic test_arst();
    int k;
    clear_obs(); mon_on = 1'b1;
    @(posedge clk); #1;
    imem_len = '0; dmem_len = '0; dump_len = '0; run_cycles = 32'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (en_cnt < 3 && k < 100) begin @(negedge clk); #1; k++; end
    n_tests++;
    if (en_cnt != 3) begin n_fail++; $display("FAIL arst_reach_run: en=%0d want 3", en_cnt); end
    arst = 1'b1;
    #1;
    n_tests++;
    if (cpu_enable !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL arst_abort: en=%b busy=%b done=%b want 0 0 0", cpu_enable, busy, done);
    end
    @(posedge clk); #1;
    arst = 1'b0; mon_on = 1'b0;
    wsrc.delete();
    run_session(0, 0, 10, 0, 0, 0, 1'b0, -1);
    n_tests++;
    if (en_cnt != 10 || busy_cyc != 10 || tmo != 0 || done !== 1'b1) begin
      n_fail++; $display("FAIL arst_rerun: en=%0d busy=%0d tmo=%0d done=%b want 10 10 0 1", en_cnt, busy_cyc, tmo, done);
    end
  endtask

  task automatic test_clamp();
    wsrc.delete();
    for (int k = 0; k < 600; k++) wsrc.push_back({$urandom, $urandom});
    run_session(600, 0, 0, 0, 0, 0, 1'b0, 100);
    n_tests++;
    if (obs_ia.size() != 512 || busy_cyc != 512 || tmo != 0) begin
      n_fail++; $display("FAIL clamp_count: writes=%0d busy=%0d tmo=%0d want 512 512 0", obs_ia.size(), busy_cyc, tmo);
    end
    n_tests++;
    if (obs_ia.size() == 0 || obs_ia[obs_ia.size()-1] !== 64'd2044) begin
      n_fail++; $display("FAIL clamp_last_addr: got %h want %h", (obs_ia.size() > 0) ? obs_ia[obs_ia.size()-1] : '1, 64'd2044);
    end
    for (int k = 0; k < obs_ia.size() && k < exp_ia.size(); k++) begin
      n_tests++;
      if (obs_ia[k] !== exp_ia[k] || obs_id[k] !== exp_id[k]) begin
        n_fail++; $display("FAIL clamp_imem[%0d]: got %h/%h want %h/%h", k, obs_ia[k], obs_id[k], exp_ia[k], exp_id[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int il, dl, rc, dp;
    for (int s = 0; s < 6; s++) begin
      il = $urandom_range(0, 6);
      dl = (s == 0) ? 64 : $urandom_range(0, 6);
      rc = $urandom_range(0, 5);
      dp = $urandom_range(0, (s == 0) ? 8 : ((dm_hi < 8) ? dm_hi : 8));
      wsrc.delete();
      for (int k = 0; k < il + dl + 2; k++) wsrc.push_back({$urandom, $urandom});
      run_session(il, dl, rc, dp, 2, 0, 1'b1, $urandom_range(2, 20));
      n_tests++;
      if (tmo != 0 || en_cnt != exp_en || excl != 0 || unstable != 0 ||
          obs_ia.size() != exp_ia.size() || obs_da.size() != exp_da.size() || obs_dump.size() != exp_dump.size()) begin
        n_fail++;
        $display("FAIL b2b_session%0d: tmo=%0d en=%0d/%0d excl=%0d unst=%0d iw=%0d/%0d dw=%0d/%0d dump=%0d/%0d",
                 s, tmo, en_cnt, exp_en, excl, unstable, obs_ia.size(), exp_ia.size(),
                 obs_da.size(), exp_da.size(), obs_dump.size(), exp_dump.size());
      end
      for (int k = 0; k < obs_ia.size() && k < exp_ia.size(); k++) begin
        n_tests++;
        if (obs_ia[k] !== exp_ia[k] || obs_id[k] !== exp_id[k]) begin
          n_fail++; $display("FAIL b2b_imem s%0d[%0d]: got %h/%h want %h/%h", s, k, obs_ia[k], obs_id[k], exp_ia[k], exp_id[k]);
        end
      end
      for (int k = 0; k < obs_da.size() && k < exp_da.size(); k++) begin
        n_tests++;
        if (obs_da[k] !== exp_da[k] || obs_dd[k] !== exp_dd[k]) begin
          n_fail++; $display("FAIL b2b_dmem s%0d[%0d]: got %h/%h want %h/%h", s, k, obs_da[k], obs_dd[k], exp_da[k], exp_dd[k]);
        end
      end
      for (int k = 0; k < obs_dump.size() && k < exp_dump.size(); k++) begin
        n_tests++;
        if (obs_dump[k] !== exp_dump[k]) begin
          n_fail++; $display("FAIL b2b_dump s%0d[%0d]: got %h want %h", s, k, obs_dump[k], exp_dump[k]);
        end
      end
      n_tests++;
      if (checksum !== exp_csum) begin
        n_fail++; $display("FAIL b2b_checksum s%0d: got %h want %h", s, checksum, exp_csum);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_run();
    test_dump();
    test_gaps();
    test_arst();
    test_clamp();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
